fetch_controller: RTL and testbench

//  Sequences the word-addressed instruction memory: owns the PC, drives the memory address and

---
 rtl/fetch_controller.sv | 75 +++++++
 tb/tb_fetch_controller.sv | 128 ++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// fetch_controller: PC owner and one-entry fetch slot to decode; optional perf counters via FETCH_PERF_CNT_EN
module fetch_controller #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 32,
  parameter int RESET_PC  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              id_ready,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              halt_req,
  input  logic              resume,
  output logic              fetch_halt
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);
  localparam logic [ADDR_W-1:0] MASK   = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC) & MASK;
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] pc;
  logic free, redirect, capture;
  assign free      = !if_valid | id_ready;
  assign redirect  = br_valid & (state != BOOT);
  assign capture   = (state == RUN) & !br_valid & !halt_req & free;
  assign imem_addr = pc;
  assign fetch_halt = state == HALT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= BOOT;
    else        state <= state_nx;
  // redirect outranks both halting and resuming
  always_comb begin
    state_nx = state;
    if (state == BOOT) state_nx = RUN;
    else if (state == RUN && !br_valid && halt_req && free) state_nx = HALT;
    else if (state == HALT && !br_valid && resume && !halt_req) state_nx = RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc       <= RST_PC;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else if (redirect) begin
      pc       <= br_target & MASK;
      if_valid <= 1'b0;
    end else if (capture) begin
      if_instr <= imem_data;
      if_pc    <= pc;
      if_valid <= 1'b1;
      pc       <= (pc + ADDR_W'(1)) & MASK;
    end else if (state == RUN && halt_req && id_ready) begin
      if_valid <= 1'b0;
    end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else if (state == RUN) begin
      if (if_valid && id_ready && !(&perf_fetched)) perf_fetched <= perf_fetched + 32'd1;
      if (if_valid && !id_ready && !(&perf_stall)) perf_stall <= perf_stall + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;
  logic        clk = 0;
  logic        rst_n, id_ready, br_valid, halt_req, resume;
  logic [31:0] br_target, imem_addr, imem_data, if_instr, if_pc;
  logic        if_valid, fetch_halt;
  int          n_chk = 0, n_fail = 0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall;
  int          exp_f = 0, exp_s = 0;
`endif
  always #5 clk = ~clk;
  assign imem_data = 32'(imem_addr[4:0]) + 32'd100;
  fetch_controller dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
    .br_valid(br_valid), .br_target(br_target), .halt_req(halt_req), .resume(resume),
    .fetch_halt(fetch_halt)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );
`ifdef FETCH_PERF_CNT_EN
  always @(negedge clk or negedge rst_n)
    if (!rst_n) begin exp_f = 0; exp_s = 0; end
    else if (if_valid) begin
      if (id_ready) exp_f++;
      else exp_s++;
    end
`endif
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic slot(input string tag, input logic [31:0] pc);
    chk({tag, "_v"}, 32'(if_valid), 1);
    chk({tag, "_pc"}, if_pc, pc);
    chk({tag, "_instr"}, if_instr, pc + 100);
  endtask
  initial begin
    rst_n = 0; id_ready = 1; br_valid = 0; br_target = 0; halt_req = 0; resume = 0;
    #12;
    chk("rst_v", 32'(if_valid), 0);
    chk("rst_instr", if_instr, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_halt", 32'(fetch_halt), 0);
    chk("rst_addr", imem_addr, 0);
    @(posedge clk); #1; rst_n = 1;
    step(); chk("boot_v", 32'(if_valid), 0);
    step(); slot("f0", 0);
    step(); slot("f1", 1);
    step(); slot("f2", 2); chk("f2_addr", imem_addr, 3);
    step(); slot("f3", 3);
    br_valid = 1; br_target = 20;
    step(); chk("br20_flush", 32'(if_valid), 0); chk("br20_addr", imem_addr, 20);
    br_valid = 0;
    step(); slot("t20", 20);
    br_valid = 1; br_target = 5;
    step(); chk("br5_flush", 32'(if_valid), 0);
    br_valid = 0;
    step(); slot("t5", 5); chk("t5_addr", imem_addr, 6);
    id_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step(); slot("stall", 5); chk("stall_addr", imem_addr, 6);
    end
    id_ready = 1;
    step(); slot("rel6", 6);
    br_valid = 1; br_target = 30;
    step(); chk("br30_flush", 32'(if_valid), 0);
    br_valid = 0;
    step(); slot("w30", 30);
    step(); slot("w31", 31);
    step(); slot("w0", 0);
    step(); slot("w1", 1);
    br_valid = 1; br_target = 32'h45;
    step(); chk("br45_flush", 32'(if_valid), 0); chk("br45_addr", imem_addr, 5);
    br_valid = 0;
    step(); slot("m5", 5); chk("m5_addr", imem_addr, 6);
    id_ready = 0; halt_req = 1;
    step(); slot("hold1", 5); chk("hold1_halt", 32'(fetch_halt), 0);
    step(); slot("hold2", 5); chk("hold2_addr", imem_addr, 6);
    id_ready = 1;
    step(); chk("halt_v", 32'(if_valid), 0); chk("halt_fh", 32'(fetch_halt), 1); chk("halt_addr", imem_addr, 6);
    halt_req = 0;
    step(); chk("halt_stay", 32'(fetch_halt), 1); chk("halt_stay_v", 32'(if_valid), 0);
    halt_req = 1; resume = 1;
    step(); chk("halt_both", 32'(fetch_halt), 1);
    halt_req = 0;
    step(); chk("resume_fh", 32'(fetch_halt), 0); chk("resume_v", 32'(if_valid), 0);
    resume = 0;
    step(); slot("r6", 6);
    halt_req = 1;
    step(); chk("halt2_fh", 32'(fetch_halt), 1); chk("halt2_v", 32'(if_valid), 0); chk("halt2_addr", imem_addr, 7);
    halt_req = 0; br_valid = 1; br_target = 12;
    step(); chk("hbr_fh", 32'(fetch_halt), 1); chk("hbr_addr", imem_addr, 12); chk("hbr_v", 32'(if_valid), 0);
    br_valid = 0; resume = 1;
    step(); chk("resume2_fh", 32'(fetch_halt), 0);
    resume = 0;
    step(); slot("r12", 12);
    step(); slot("r13", 13);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, 32'(exp_f));
    chk("perf_stall", perf_stall, 32'(exp_s));
`endif
    #3; rst_n = 0; #1;
    chk("mrst_v", 32'(if_valid), 0);
    chk("mrst_addr", imem_addr, 0);
    chk("mrst_pc", if_pc, 0);
    chk("mrst_instr", if_instr, 0);
    chk("mrst_fh", 32'(fetch_halt), 0);
`ifdef FETCH_PERF_CNT_EN
    chk("mrst_pf", perf_fetched, 0);
    chk("mrst_ps", perf_stall, 0);
`endif
    @(posedge clk); #1; rst_n = 1;
    step(); chk("reboot_v", 32'(if_valid), 0);
    step(); slot("rs0", 0);
    step(); slot("rs1", 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
